// File: rtl/bishop_move_checker.sv
// Bishop move legality checker: latches a move, lets the external range stage settle,
// then grades the move. Result counters exist only when BISHOP_MOVE_STATS_EN is defined.
module bishop_move_checker (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_src_row,
  input  logic [2:0]  req_src_col,
  input  logic [2:0]  req_dst_row,
  input  logic [2:0]  req_dst_col,
  input  logic        req_color,
  output logic [2:0]  chk_row,
  output logic [2:0]  chk_col,
  output logic        chk_color,
  input  logic [2:0]  allow_ul,
  input  logic [2:0]  allow_ur,
  input  logic [2:0]  allow_dr,
  input  logic [2:0]  allow_dl,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_legal,
  output logic [1:0]  rsp_reason,
  output logic [2:0]  rsp_dist,
  output logic [15:0] stat_legal,
  output logic [15:0] stat_illegal
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
  // rsp_* hold stable while rsp_valid=1 and rsp_ready=0.
  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_DECIDE, S_RESP} state_t;

  localparam logic [1:0] RSN_OK       = 2'b00;
  localparam logic [1:0] RSN_NULL     = 2'b01;
  localparam logic [1:0] RSN_NOT_DIAG = 2'b10;
  localparam logic [1:0] RSN_BLOCKED  = 2'b11;

  state_t     state_q;
  logic [2:0] src_row_q, src_col_q, dst_row_q, dst_col_q;
  logic       color_q;
  logic       ready_q, valid_q, legal_q;
  logic [1:0] reason_q;
  logic [2:0] dist_q;

  logic [3:0] dr, dc, abs_dr, abs_dc;
  logic [2:0] allow_sel;
  logic       legal_d;
  logic [1:0] reason_d;
  logic [2:0] dist_d;

  // 4-bit two's-complement differences; bit 3 is the sign.
  always_comb begin
    dr       = {1'b0, dst_row_q} - {1'b0, src_row_q};
    dc       = {1'b0, dst_col_q} - {1'b0, src_col_q};
    abs_dr   = dr[3] ? (4'd0 - dr) : dr;
    abs_dc   = dc[3] ? (4'd0 - dc) : dc;
    case ({dr[3], dc[3]})
      2'b11:   allow_sel = allow_ul;
      2'b10:   allow_sel = allow_ur;
      2'b01:   allow_sel = allow_dl;
      default: allow_sel = allow_dr;
    endcase
    if (abs_dr == 4'd0 && abs_dc == 4'd0) begin
      reason_d = RSN_NULL;
    end else if (abs_dr != abs_dc) begin
      reason_d = RSN_NOT_DIAG;
    end else if (abs_dr[2:0] > allow_sel) begin
      reason_d = RSN_BLOCKED;
    end else begin
      reason_d = RSN_OK;
    end
    legal_d = (reason_d == RSN_OK);
    dist_d  = (reason_d == RSN_NULL || reason_d == RSN_NOT_DIAG) ? 3'd0 : abs_dr[2:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      src_row_q <= 3'd0;
      src_col_q <= 3'd0;
      dst_row_q <= 3'd0;
      dst_col_q <= 3'd0;
      color_q   <= 1'b0;
      ready_q   <= 1'b1;
      valid_q   <= 1'b0;
      legal_q   <= 1'b0;
      reason_q  <= RSN_OK;
      dist_q    <= 3'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            src_row_q <= req_src_row;
            src_col_q <= req_src_col;
            dst_row_q <= req_dst_row;
            dst_col_q <= req_dst_col;
            color_q   <= req_color;
            ready_q   <= 1'b0;
            state_q   <= S_SETTLE;
          end
        end
        S_SETTLE: state_q <= S_DECIDE;
        S_DECIDE: begin
          legal_q  <= legal_d;
          reason_q <= reason_d;
          dist_q   <= dist_d;
          valid_q  <= 1'b1;
          state_q  <= S_RESP;
        end
        default: begin
          if (rsp_ready) begin
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            state_q <= S_IDLE;
          end
        end
      endcase
    end
  end

`ifdef BISHOP_MOVE_STATS_EN
  logic [15:0] stat_legal_q, stat_illegal_q;
  logic        rsp_fire;

  assign rsp_fire = (state_q == S_RESP) && rsp_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_legal_q   <= 16'd0;
      stat_illegal_q <= 16'd0;
    end else if (rsp_fire) begin
      if (legal_q) begin
        if (stat_legal_q != 16'hFFFF) stat_legal_q <= stat_legal_q + 16'd1;
      end else begin
        if (stat_illegal_q != 16'hFFFF) stat_illegal_q <= stat_illegal_q + 16'd1;
      end
    end
  end

  assign stat_legal   = stat_legal_q;
  assign stat_illegal = stat_illegal_q;
`else
  assign stat_legal   = 16'd0;
  assign stat_illegal = 16'd0;
`endif

  assign req_ready  = ready_q;
  assign rsp_valid  = valid_q;
  assign rsp_legal  = legal_q;
  assign rsp_reason = reason_q;
  assign rsp_dist   = dist_q;
  assign chk_row    = src_row_q;
  assign chk_col    = src_col_q;
  assign chk_color  = color_q;

endmodule
